if_stage: RTL

Instruction-fetch stage of the 5-stage pipeline CPU. It owns the fetch PC, drives a synchronous-read instruction memory, and produces the IF/ID pipeline register consumed by decode. It applies the hazard unit's stall, the EX-stage branch redirect, trap redirects and IF/ID flush, and exposes fetch/bubble counters for the simulation monitor.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_stage_if.sv | 32 +++
 rtl/pc_sel.sv | 26 ++
 rtl/if_stage.sv | 85 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline-register payload.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
        logic            misalign;
    } ifid_t;

    // A PC that is not word aligned is flagged for decode to trap on
    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction memory port plus the IF/ID register outputs.
interface if_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] IFID_pc;
    logic [XLEN-1:0] IFID_inst;
    logic            IFID_valid;
    logic            IFID_misalign;

    // Fetch stage drives the address and IF/ID, memory returns data
    modport master (
        output imem_addr,
        input  imem_rdata,
        output IFID_pc,
        output IFID_inst,
        output IFID_valid,
        output IFID_misalign
    );

    // Memory / decode side view
    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  IFID_pc,
        input  IFID_inst,
        input  IFID_valid,
        input  IFID_misalign
    );

endinterface

// File: rtl/pc_sel.sv
// Next-PC priority mux: trap, then branch, then stall hold, else sequential.
module pc_sel
    import cpu_pkg::*;
(
    input  logic            trap_taken_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o
);

    // Redirects override the stall; sequential fetch wraps at 2^32
    always_comb begin
        next_pc_o = pc_i + XLEN'(4);
        if (trap_taken_i) begin
            next_pc_o = trap_target_i;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target_i;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives imem, builds IF/ID.
module if_stage
    import cpu_pkg::XLEN;
    import cpu_pkg::ifid_t;
    import cpu_pkg::is_misaligned;
#(
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush_IFID,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              trap_taken,
    input  logic [XLEN-1:0]   trap_target,
    if_stage_if.master        bus,
    output logic [XLEN-1:0]   PC_IF,
    output logic [XLEN-1:0]   fetch_count,
    output logic [XLEN-1:0]   bubble_count
);

    logic [XLEN-1:0] next_pc_c;
    logic            bubble_c;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    pc_sel u_pc_sel (
        .trap_taken_i    (trap_taken),
        .trap_target_i   (trap_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .stall_i         (stall),
        .pc_i            (pc_q),
        .next_pc_o       (next_pc_c)
    );

    // Memory reads next_pc so that its registered data is the word at PC_IF
    assign bus.imem_addr = rst ? RESET_PC : next_pc_c;

    assign bubble_c = trap_taken | branch_taken | flush_IFID;

    // Next-state for PC, IF/ID and counters; redirect/flush beats stall
    always_comb begin
        pc_d         = next_pc_c;
        ifid_d       = ifid_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_c) begin
            ifid_d       = '{pc: pc_q, inst: NOP_INST, valid: 1'b0, misalign: 1'b0};
            bubble_cnt_d = bubble_cnt_q + XLEN'(1);
        end else if (!stall) begin
            ifid_d       = '{pc: pc_q, inst: bus.imem_rdata, valid: 1'b1,
                             misalign: is_misaligned(pc_q)};
            fetch_cnt_d  = fetch_cnt_q + XLEN'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_q       <= '{pc: RESET_PC, inst: NOP_INST, valid: 1'b0, misalign: 1'b0};
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_q       <= ifid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign PC_IF             = pc_q;
    assign bus.IFID_pc       = ifid_q.pc;
    assign bus.IFID_inst     = ifid_q.inst;
    assign bus.IFID_valid    = ifid_q.valid;
    assign bus.IFID_misalign = ifid_q.misalign;
    assign fetch_count       = fetch_cnt_q;
    assign bubble_count      = bubble_cnt_q;

endmodule
